issue_select: RTL and testbench

- Downstream consumer of the issue queue. Each cycle it scans the queue's compacted entries, where index 0 is the oldest.
- It picks the oldest entry that is hazard-free and loads it into a one-entry issue register with a valid/ready handshake toward the execute stage.
- It drives the queue's per-entry pop vector so the queue removes the issued entry on the same edge.
- It keeps a register-busy scoreboard: bits are set at issue and cleared by writeback broadcast.

---
 rtl/issue_pkg.sv | 25 ++
 rtl/issue_select_scoreboard.sv | 36 +++
 rtl/issue_select.sv | 111 +++++++++++
 tb/tb_issue_select.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_pkg.sv
// rtl/issue_pkg.sv - uop format and register-use helpers shared by the issue stage
package issue_pkg;

   typedef logic [4:0] tag_t;

   typedef struct packed {
      tag_t        rd;
      tag_t        rs1;
      tag_t        rs2;
      logic        use_rs1;
      logic        use_rs2;
      logic        writes_rd;
      logic [31:0] payload;
   } uop_t;

   // Register 0 is hardwired, so it never creates a dependency.
   function automatic logic writes_reg(uop_t u);
      return u.writes_rd && (u.rd != '0);
   endfunction

   function automatic logic reads_reg(uop_t u, tag_t t);
      return (t != '0) && ((u.use_rs1 && (u.rs1 == t)) || (u.use_rs2 && (u.rs2 == t)));
   endfunction

endpackage

// File: rtl/issue_select_scoreboard.sv
// rtl/issue_select_scoreboard.sv - register busy vector with set/clear and per-tag busy queries
module issue_select_scoreboard #(
   parameter int Regs = 32,
   parameter int NumQ = 1,
   localparam int TagWidth = $clog2(Regs)
) (
   input  logic                clk_n,
   input  logic                rst,
   input  logic                set_valid,
   input  logic [TagWidth-1:0] set_tag,
   input  logic                clr_valid,
   input  logic [TagWidth-1:0] clr_tag,
   input  logic [TagWidth-1:0] query_tag [NumQ],
   output logic                query_busy [NumQ]
);

   logic [Regs-1:0] busy;

   // Set is applied after clear so an issue overrides a same-edge writeback.
   always_ff @(negedge clk_n) begin
      if (rst) begin
         busy <= '0;
      end else begin
         if (clr_valid) busy[clr_tag] <= 1'b0;
         if (set_valid) busy[set_tag] <= 1'b1;
         busy[0] <= 1'b0;
      end
   end

   always_comb begin
      for (int k = 0; k < NumQ; k++) begin
         query_busy[k] = busy[query_tag[k]];
      end
   end

endmodule

// File: rtl/issue_select.sv
// rtl/issue_select.sv - oldest-ready select from the issue queue into a one-entry issue register
module issue_select
   import issue_pkg::*;
#(
   parameter int Size = 16,
   parameter int Regs = 32,
   localparam int Width = $clog2(Size),
   localparam int TagWidth = $clog2(Regs)
) (
   input  logic                clk_ni,
   input  logic                rst_i,
   input  logic [Width:0]      size_i,
   input  uop_t                entries_i [Size],
   output logic                pop_o [Size],
   output logic                issue_valid_o,
   output uop_t                issue_uop_o,
   input  logic                issue_ready_i,
   input  logic                wb_valid_i,
   input  logic [TagWidth-1:0] wb_tag_i
);

   localparam int NumQ = 3 * Size;

   logic [TagWidth-1:0] query_tag [NumQ];
   logic                query_busy [NumQ];
   logic [Size-1:0]     eligible;
   logic                found;
   logic [Width-1:0]    sel;
   logic                accept;
   logic                do_issue;

   function automatic logic wb_hit(tag_t t);
      return wb_valid_i && (wb_tag_i == t);
   endfunction

   // Query slots per entry: rs1, rs2, rd.
   always_comb begin
      for (int j = 0; j < Size; j++) begin
         query_tag[3*j]   = entries_i[j].rs1;
         query_tag[3*j+1] = entries_i[j].rs2;
         query_tag[3*j+2] = entries_i[j].rd;
      end
   end

   issue_select_scoreboard #(.Regs(Regs), .NumQ(NumQ)) u_scoreboard (
      .clk_n      (clk_ni),
      .rst        (rst_i),
      .set_valid  (do_issue && writes_reg(entries_i[sel])),
      .set_tag    (entries_i[sel].rd),
      .clr_valid  (wb_valid_i),
      .clr_tag    (wb_tag_i),
      .query_tag  (query_tag),
      .query_busy (query_busy)
   );

   // Any live older entry is also live, so ordering checks need no liveness term of their own.
   always_comb begin
      eligible = '0;
      for (int j = 0; j < Size; j++) begin
         logic src_ok;
         logic hazard;
         src_ok = !(entries_i[j].use_rs1 && (entries_i[j].rs1 != '0) && query_busy[3*j]
                    && !wb_hit(entries_i[j].rs1))
               && !(entries_i[j].use_rs2 && (entries_i[j].rs2 != '0) && query_busy[3*j+1]
                    && !wb_hit(entries_i[j].rs2))
               && !(writes_reg(entries_i[j]) && query_busy[3*j+2] && !wb_hit(entries_i[j].rd));
         hazard = 1'b0;
         for (int i = 0; i < Size; i++) begin
            if (i < j) begin
               hazard = hazard
                  | (writes_reg(entries_i[i]) && reads_reg(entries_i[j], entries_i[i].rd))
                  | (writes_reg(entries_i[j]) && reads_reg(entries_i[i], entries_i[j].rd))
                  | (writes_reg(entries_i[i]) && writes_reg(entries_i[j])
                     && (entries_i[i].rd == entries_i[j].rd));
            end
         end
         eligible[j] = ((Width+1)'(j) < size_i) && src_ok && !hazard;
      end
   end

   always_comb begin
      found = 1'b0;
      sel   = '0;
      for (int j = Size - 1; j >= 0; j--) begin
         if (eligible[j]) begin
            found = 1'b1;
            sel   = Width'(j);
         end
      end
   end

   assign accept   = !issue_valid_o || issue_ready_i;
   assign do_issue = !rst_i && accept && found;

   always_comb begin
      for (int j = 0; j < Size; j++) begin
         pop_o[j] = do_issue && (sel == Width'(j));
      end
   end

   always_ff @(negedge clk_ni) begin
      if (rst_i) begin
         issue_valid_o <= 1'b0;
         issue_uop_o   <= '0;
      end else if (accept) begin
         issue_valid_o <= found;
         if (found) issue_uop_o <= entries_i[sel];
      end
   end

endmodule

// File: tb/tb_issue_select.sv
// tb/tb_issue_select.sv - directed and randomized checks of issue_select against a queue-level model
module tb_issue_select;
   import issue_pkg::*;

   localparam int Size = 16;
   localparam int Regs = 32;

   logic        clk = 1'b1;
   logic        rst = 1'b1;
   int          qn = 0;
   logic [4:0]  size_v;
   uop_t        q [Size];
   logic        pop_o [Size];
   logic        vld;
   uop_t        uop;
   logic        ready = 1'b0;
   logic        wb_valid = 1'b0;
   tag_t        wb_tag = '0;

   int n_checks = 0;
   int n_pass = 0;

   bit              m_valid;
   uop_t            m_uop;
   bit              m_busy [Regs];
   int              exp_idx;
   logic [Size-1:0] exp_pop;
   logic [Size-1:0] pop_vec;

   always #5 clk = ~clk;

   assign size_v = 5'(qn);

   always_comb begin
      for (int i = 0; i < Size; i++) pop_vec[i] = pop_o[i];
   end

   issue_select dut (
      .clk_ni        (clk),
      .rst_i         (rst),
      .size_i        (size_v),
      .entries_i     (q),
      .pop_o         (pop_o),
      .issue_valid_o (vld),
      .issue_uop_o   (uop),
      .issue_ready_i (ready),
      .wb_valid_i    (wb_valid),
      .wb_tag_i      (wb_tag)
   );

   function automatic uop_t mk(tag_t rd, bit wr, tag_t rs1, bit u1, tag_t rs2, bit u2, logic [31:0] pl);
      uop_t u;
      u.rd = rd; u.writes_rd = wr;
      u.rs1 = rs1; u.use_rs1 = u1;
      u.rs2 = rs2; u.use_rs2 = u2;
      u.payload = pl;
      return u;
   endfunction

   function automatic uop_t rand_uop();
      return mk(tag_t'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                tag_t'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                tag_t'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom);
   endfunction

   // Model view of the rules: a register counts as written/read only if nonzero and actually used.
   function automatic bit m_writes(uop_t u, tag_t r);
      return u.writes_rd && (u.rd == r) && (r != 0);
   endfunction

   function automatic bit m_reads(uop_t u, tag_t r);
      return (r != 0) && ((u.use_rs1 && u.rs1 == r) || (u.use_rs2 && u.rs2 == r));
   endfunction

   function automatic bit m_free(tag_t r);
      return (r == 0) || !m_busy[r] || (wb_valid && wb_tag == r);
   endfunction

   function automatic bit m_eligible(int j);
      uop_t u;
      if (j >= qn) return 0;
      u = q[j];
      if (u.use_rs1 && !m_free(u.rs1)) return 0;
      if (u.use_rs2 && !m_free(u.rs2)) return 0;
      if (u.writes_rd && !m_free(u.rd)) return 0;
      for (int i = 0; i < j; i++) begin
         if (q[i].writes_rd && m_reads(u, q[i].rd)) return 0;
         if (u.writes_rd && m_reads(q[i], u.rd)) return 0;
         if (u.writes_rd && m_writes(q[i], u.rd)) return 0;
      end
      return 1;
   endfunction

   task automatic push(uop_t u);
      q[qn] = u;
      qn++;
   endtask

   task automatic settle();
      @(posedge clk);
      exp_idx = -1;
      exp_pop = '0;
      if (!rst && (!m_valid || ready)) begin
         for (int j = 0; j < Size; j++) begin
            if (exp_idx < 0 && m_eligible(j)) exp_idx = j;
         end
      end
      if (exp_idx >= 0) exp_pop[exp_idx] = 1'b1;
   endtask

   task automatic advance();
      uop_t issued;
      if (rst) begin
         m_valid = 0;
         m_uop = '0;
         for (int r = 0; r < Regs; r++) m_busy[r] = 0;
      end else begin
         if (!m_valid || ready) begin
            if (exp_idx >= 0) begin
               issued = q[exp_idx];
               m_uop = issued;
               m_valid = 1;
            end else begin
               m_valid = 0;
            end
         end
         if (wb_valid) m_busy[wb_tag] = 0;
         if (exp_idx >= 0 && issued.writes_rd && issued.rd != 0) m_busy[issued.rd] = 1;
      end
      @(negedge clk);
      #1;
      if (exp_idx >= 0) begin
         for (int i = exp_idx; i < Size - 1; i++) q[i] = q[i+1];
         q[Size-1] = rand_uop();
         qn--;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      ready = 1'b0;
      wb_valid = 1'b0;
      qn = 0;
      for (int i = 0; i < Size; i++) q[i] = rand_uop();
      settle();
      advance();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      uop_t a;
      do_reset();
      n_checks++; if (vld !== 1'b0) $display("FAIL reset_valid: got %b want 0", vld); else n_pass++;
      n_checks++; if (uop !== '0) $display("FAIL reset_uop: got %h want 0", uop); else n_pass++;
      push(mk(5'd5, 1, 5'd0, 0, 5'd0, 0, 32'h5555));
      settle();
      n_checks++; if (pop_vec !== 16'h0001) $display("FAIL reset_first_pop: got %h want 0001", pop_vec); else n_pass++;
      advance();
      push(mk(5'd6, 1, 5'd0, 0, 5'd0, 0, 32'h6666));
      settle();
      n_checks++; if (pop_vec !== 16'h0000) $display("FAIL reset_stall_pop: got %h want 0000", pop_vec); else n_pass++;
      n_checks++; if (vld !== 1'b1) $display("FAIL reset_stall_valid: got %b want 1", vld); else n_pass++;
      advance();
      rst = 1'b1;
      ready = 1'b1;
      settle();
      n_checks++; if (pop_vec !== 16'h0000) $display("FAIL reset_pop_forced: got %h want 0000", pop_vec); else n_pass++;
      advance();
      rst = 1'b0;
      n_checks++; if (vld !== 1'b0) $display("FAIL reset_mid_valid: got %b want 0", vld); else n_pass++;
      n_checks++; if (uop !== '0) $display("FAIL reset_mid_uop: got %h want 0", uop); else n_pass++;
      qn = 0;
      a = mk(5'd10, 1, 5'd5, 1, 5'd6, 1, 32'hA0A0);
      push(a);
      settle();
      n_checks++; if (pop_vec !== 16'h0001) $display("FAIL reset_busy_cleared: got %h want 0001", pop_vec); else n_pass++;
      advance();
   endtask

   task automatic test_raw_bypass();
      uop_t e1;
      do_reset();
      ready = 1'b1;
      e1 = mk(5'd4, 1, 5'd3, 1, 5'd0, 0, 32'hE1);
      push(mk(5'd3, 1, 5'd1, 1, 5'd0, 0, 32'hE0));
      push(e1);
      settle();
      n_checks++; if (pop_vec !== 16'h0001) $display("FAIL raw_cycle0_pop: got %h want 0001", pop_vec); else n_pass++;
      advance();
      settle();
      n_checks++; if (pop_vec !== 16'h0000) $display("FAIL raw_busy_block: got %h want 0000", pop_vec); else n_pass++;
      advance();
      wb_valid = 1'b1;
      wb_tag = 5'd3;
      settle();
      n_checks++; if (pop_vec !== 16'h0001) $display("FAIL raw_wb_bypass: got %h want 0001", pop_vec); else n_pass++;
      advance();
      wb_valid = 1'b0;
      n_checks++; if (uop !== e1 || vld !== 1'b1) $display("FAIL raw_issued_uop: got %h/%b want %h/1", uop, vld, e1); else n_pass++;
   endtask

   task automatic test_out_of_order();
      uop_t e1;
      do_reset();
      ready = 1'b1;
      push(mk(5'd7, 1, 5'd0, 0, 5'd0, 0, 32'h77));
      settle();
      advance();
      e1 = mk(5'd9, 1, 5'd0, 0, 5'd0, 0, 32'h99);
      push(mk(5'd0, 0, 5'd7, 1, 5'd0, 0, 32'h70));
      push(e1);
      settle();
      n_checks++; if (pop_vec !== 16'h0002) $display("FAIL ooo_pop: got %h want 0002", pop_vec); else n_pass++;
      advance();
      n_checks++; if (uop !== e1) $display("FAIL ooo_uop: got %h want %h", uop, e1); else n_pass++;
   endtask

   task automatic test_war();
      uop_t e1;
      do_reset();
      ready = 1'b1;
      push(mk(5'd8, 1, 5'd0, 0, 5'd0, 0, 32'h88));
      settle();
      advance();
      e1 = mk(5'd9, 1, 5'd0, 0, 5'd0, 0, 32'h9E);
      push(mk(5'd0, 0, 5'd9, 1, 5'd8, 1, 32'h9D));
      push(e1);
      for (int c = 0; c < 2; c++) begin
         settle();
         n_checks++; if (pop_vec !== 16'h0000) $display("FAIL war_hold_%0d: got %h want 0000", c, pop_vec); else n_pass++;
         advance();
      end
      wb_valid = 1'b1;
      wb_tag = 5'd8;
      settle();
      n_checks++; if (pop_vec !== 16'h0001) $display("FAIL war_older_issue: got %h want 0001", pop_vec); else n_pass++;
      advance();
      wb_valid = 1'b0;
      settle();
      n_checks++; if (pop_vec !== 16'h0001) $display("FAIL war_younger_issue: got %h want 0001", pop_vec); else n_pass++;
      advance();
      n_checks++; if (uop !== e1) $display("FAIL war_uop: got %h want %h", uop, e1); else n_pass++;
   endtask

   task automatic test_stall();
      uop_t a;
      uop_t b;
      do_reset();
      a = mk(5'd11, 1, 5'd0, 0, 5'd0, 0, 32'hAAAA);
      b = mk(5'd12, 1, 5'd0, 0, 5'd0, 0, 32'hBBBB);
      push(a);
      settle();
      n_checks++; if (pop_vec !== 16'h0001) $display("FAIL stall_load_pop: got %h want 0001", pop_vec); else n_pass++;
      advance();
      push(b);
      for (int c = 0; c < 3; c++) begin
         settle();
         n_checks++; if (pop_vec !== 16'h0000) $display("FAIL stall_pop_%0d: got %h want 0000", c, pop_vec); else n_pass++;
         n_checks++; if (uop !== a) $display("FAIL stall_uop_%0d: got %h want %h", c, uop, a); else n_pass++;
         advance();
      end
      ready = 1'b1;
      settle();
      n_checks++; if (pop_vec !== 16'h0001) $display("FAIL stall_release_pop: got %h want 0001", pop_vec); else n_pass++;
      advance();
      n_checks++; if (uop !== b) $display("FAIL stall_new_uop: got %h want %h", uop, b); else n_pass++;
   endtask

   task automatic test_size_zero();
      uop_t a;
      uop_t b;
      do_reset();
      a = mk(5'd0, 1, 5'd0, 0, 5'd0, 0, 32'hC0C0);
      b = mk(5'd0, 1, 5'd0, 1, 5'd0, 0, 32'hD0D0);
      push(a);
      settle();
      advance();
      for (int i = 0; i < Size; i++) q[i] = mk(5'd13, 1, 5'd0, 0, 5'd0, 0, 32'hF00D + i);
      qn = 0;
      settle();
      n_checks++; if (pop_vec !== 16'h0000) $display("FAIL empty_pop_stalled: got %h want 0000", pop_vec); else n_pass++;
      n_checks++; if (vld !== 1'b1) $display("FAIL empty_valid_held: got %b want 1", vld); else n_pass++;
      advance();
      ready = 1'b1;
      settle();
      n_checks++; if (pop_vec !== 16'h0000) $display("FAIL empty_pop_ready: got %h want 0000", pop_vec); else n_pass++;
      advance();
      n_checks++; if (vld !== 1'b0) $display("FAIL empty_valid_drop: got %b want 0", vld); else n_pass++;
      n_checks++; if (uop !== a) $display("FAIL empty_uop_hold: got %h want %h", uop, a); else n_pass++;
      push(b);
      settle();
      n_checks++; if (pop_vec !== 16'h0001) $display("FAIL reg0_never_busy: got %h want 0001", pop_vec); else n_pass++;
      advance();
      n_checks++; if (uop !== b || vld !== 1'b1) $display("FAIL reg0_uop: got %h/%b want %h/1", uop, vld, b); else n_pass++;
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 400; c++) begin
         if (qn < Size && $urandom_range(0, 1) == 1) push(rand_uop());
         ready = ($urandom_range(0, 3) != 0);
         wb_valid = ($urandom_range(0, 2) == 0);
         wb_tag = tag_t'($urandom_range(0, 7));
         settle();
         n_checks++; if (pop_vec !== exp_pop) $display("FAIL rand_pop c=%0d: got %h want %h", c, pop_vec, exp_pop); else n_pass++;
         n_checks++; if (vld !== m_valid) $display("FAIL rand_valid c=%0d: got %b want %b", c, vld, m_valid); else n_pass++;
         n_checks++; if (uop !== m_uop) $display("FAIL rand_uop c=%0d: got %h want %h", c, uop, m_uop); else n_pass++;
         advance();
      end
      wb_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_raw_bypass();
      test_out_of_order();
      test_war();
      test_stall();
      test_size_zero();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
